// File: rtl/seq_det_arbiter.sv
// rtl/seq_det_arbiter.sv - round-robin arbiter sharing one Moore "1011" detector across serial channels
// Optional early-abort of a frame when the granted request drops: SEQ_ARB_ABORT_EN.
module seq_det_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int FRAME_LEN = 16,
    parameter int CH_W      = 2,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] grant,
    output logic              det_clr,
    output logic              det_x,
    input  logic              det_y,
    output logic              busy,
    output logic              frame_done,
    output logic [CH_W-1:0]   frame_ch,
`ifdef SEQ_ARB_ABORT_EN
    output logic              frame_abort,
`endif
    output logic [CNT_W-1:0]  frame_hits
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_BIT = 8'(FRAME_LEN - 1);

    state_t           state, state_nx;
    logic [CH_W-1:0]  idx, idx_nx, pick, rr_ptr;
    logic [7:0]       bit_cnt;
    logic [CNT_W-1:0] hit_cnt, hit_cnt_nx;
    logic             found;
    logic             abort_nx;

    // First requester at or after rr_ptr, wrapping around the channel list.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            int j;
            j = (int'(rr_ptr) + i) % NUM_CH;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = CH_W'(j);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        abort_nx   = 1'b0;
        hit_cnt_nx = hit_cnt;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx = S_CLEAR;
                    idx_nx   = pick;
                end
            end
            S_CLEAR: begin
                state_nx   = S_STREAM;
                hit_cnt_nx = '0;
            end
            S_STREAM: begin
`ifdef SEQ_ARB_ABORT_EN
                if (!req[idx]) begin
                    state_nx = S_DONE;
                    abort_nx = 1'b1;
                end else
`endif
                if (bit_cnt == LAST_BIT) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Saturating hit counter; det_y is meaningful in STREAM and DRAIN only.
        if ((state == S_STREAM || state == S_DRAIN) && det_y && hit_cnt != {CNT_W{1'b1}}) begin
            hit_cnt_nx = hit_cnt + 1'b1;
        end
    end

    assign det_x = (state == S_STREAM) ? ch_bit[idx] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            rr_ptr     <= '0;
            bit_cnt    <= '0;
            hit_cnt    <= '0;
            grant      <= '0;
            det_clr    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_ch   <= '0;
            frame_hits <= '0;
`ifdef SEQ_ARB_ABORT_EN
            frame_abort <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            hit_cnt <= hit_cnt_nx;
            if (state == S_CLEAR) begin
                bit_cnt <= '0;
            end else if (state == S_STREAM) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == S_DONE) begin
                rr_ptr <= (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
            end
            // Outputs are registered from the next state so they line up with the state they describe.
            grant      <= (state_nx == S_CLEAR || state_nx == S_STREAM || state_nx == S_DRAIN)
                          ? (NUM_CH'(1) << idx_nx) : '0;
            det_clr    <= (state_nx == S_CLEAR);
            busy       <= (state_nx != S_IDLE);
            frame_done <= (state_nx == S_DONE);
`ifdef SEQ_ARB_ABORT_EN
            frame_abort <= abort_nx;
`endif
            if (state_nx == S_DONE) begin
                frame_ch   <= idx;
                frame_hits <= hit_cnt_nx;
            end
        end
    end

`ifndef SEQ_ARB_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort_nx;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb/tb_seq_det_arbiter.sv - scoreboard bench for seq_det_arbiter with an external 1011 detector
module tb_seq_det_arbiter;

    localparam int NUM_CH    = 4;
    localparam int FRAME_LEN = 16;
    localparam int CH_W      = 2;
    localparam int CNT_W     = 8;

    typedef struct {
        int ch;
        int hits;
        bit abrt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] req = '0;
    logic [NUM_CH-1:0] ch_bit = '0;
    logic [NUM_CH-1:0] grant;
    logic              det_clr, det_x, det_y, busy, frame_done;
    logic [CH_W-1:0]   frame_ch;
    logic [CNT_W-1:0]  frame_hits;
`ifdef SEQ_ARB_ABORT_EN
    logic              frame_abort;
`endif

    seq_det_arbiter #(
        .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .ch_bit(ch_bit), .grant(grant),
        .det_clr(det_clr), .det_x(det_x), .det_y(det_y), .busy(busy),
        .frame_done(frame_done), .frame_ch(frame_ch),
`ifdef SEQ_ARB_ABORT_EN
        .frame_abort(frame_abort),
`endif
        .frame_hits(frame_hits)
    );

    always #5 clk = ~clk;

    // Shared Moore 1011 detector with synchronous clear.
    logic [2:0] dst = 3'd0;
    always_ff @(posedge clk) begin
        if (det_clr) dst <= 3'd0;
        else case (dst)
            3'd0: dst <= det_x ? 3'd1 : 3'd0;
            3'd1: dst <= det_x ? 3'd1 : 3'd2;
            3'd2: dst <= det_x ? 3'd3 : 3'd0;
            3'd3: dst <= det_x ? 3'd4 : 3'd2;
            default: dst <= det_x ? 3'd1 : 3'd2;
        endcase
    end
    assign det_y = (dst == 3'd4);

    int   n_pass = 0;
    int   n_chk  = 0;
    logic [15:0] pat [NUM_CH];
    int   ab_len [NUM_CH];
    exp_t sb_q [$];
    int   got_ch [$];
    int   frames = 0;
    int   cyc = 0;
    int   rr_m = 0;
    int   clr_cyc = 0, done_cyc = 0, gcnt = 0, exp_ch = 0;
    bit   in_frame = 0, have_done = 0, chk_gap = 0;
    int   sptr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    function automatic int count_hits(input logic [15:0] p, input int n);
        int c = 0;
        for (int i = 3; i < n; i++)
            if (p[i-3] && !p[i-2] && p[i-1] && p[i]) c++;
        return c;
    endfunction

    // Serial sources: bit 0 of each pattern appears in the first STREAM cycle.
    always @(posedge clk) begin
        #1;
        if (det_clr) sptr = 0;
        else if (busy) begin
            for (int c = 0; c < NUM_CH; c++) ch_bit[c] = (sptr < 16) ? pat[c][sptr] : 1'b0;
            sptr++;
        end
    end

    // Monitor: pushes expectations at frame start, pops and compares at frame_done.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            sb_q.delete();
            rr_m = 0; in_frame = 0; have_done = 0;
        end else begin
            if (in_frame && grant == (NUM_CH'(1) << exp_ch)) gcnt++;
            if (det_clr) begin
                exp_t e;
                exp_ch = -1;
                for (int i = 0; i < NUM_CH; i++)
                    if (exp_ch < 0 && req[(rr_m + i) % NUM_CH]) exp_ch = (rr_m + i) % NUM_CH;
                e.ch   = exp_ch;
                e.hits = count_hits(pat[exp_ch], ab_len[exp_ch]);
                e.abrt = (ab_len[exp_ch] != FRAME_LEN);
                sb_q.push_back(e);
                rr_m = (exp_ch + 1) % NUM_CH;
                in_frame = 1;
                gcnt = (grant == (NUM_CH'(1) << exp_ch)) ? 1 : 0;
                clr_cyc = cyc;
                if (chk_gap && have_done) check("idle_gap", cyc - done_cyc, 2);
            end
            if (frame_done) begin
                if (sb_q.size() == 0) check("sb_empty", 0, 1);
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("frame_ch", frame_ch, e.ch);
                    check("frame_hits", frame_hits, e.hits);
`ifdef SEQ_ARB_ABORT_EN
                    check("frame_abort", frame_abort, e.abrt);
`endif
                    if (!e.abrt) begin
                        check("done_latency", cyc - clr_cyc, FRAME_LEN + 2);
                        check("grant_cycles", gcnt, FRAME_LEN + 2);
                    end
                end
                got_ch.push_back(int'(frame_ch));
                frames++;
                done_cyc = cyc;
                have_done = 1;
                in_frame = 0;
            end
        end
    end

    task automatic wait_frames(input int n);
        int target = frames + n;
        for (int i = 0; i < 40 * (FRAME_LEN + 4) * n; i++) begin
            @(posedge clk); #3;
            if (frames >= target) return;
        end
        check("timeout_frames", frames, target);
    endtask

    task automatic wait_clr();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #3;
            if (det_clr) return;
        end
        check("timeout_clr", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_det_clr"}, det_clr, 0);
        check({tag, "_det_x"}, det_x, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_ch"}, frame_ch, 0);
        check({tag, "_hits"}, frame_hits, 0);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            pat[c] = '0;
            ab_len[c] = FRAME_LEN;
        end
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b0;

        pat[1] = 16'h000D;
        req = 4'b0010;
        wait_frames(1);
        req = '0;
        check("t2_ch", frame_ch, 1);
        check("t2_hits", frame_hits, 1);

        pat[0] = 16'h036D;
        req = 4'b0001;
        wait_frames(1);
        req = '0;
        check("t3_hits", frame_hits, 3);

        pat[0] = 16'hD000;
        req = 4'b0001;
        wait_frames(1);
        req = '0;
        check("t5_hits", frame_hits, 1);

        pat[2] = 16'hFFFF;
        req = 4'b0100;
        wait_clr();
        repeat (5) @(posedge clk);
        #2 check("mid_det_x", det_x, 1);
        rst = 1'b1;
        #1 check_idle_outputs("midrst");
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        pat[0] = 16'h000D; pat[1] = 16'h036D; pat[2] = 16'hD000; pat[3] = 16'hDDDD;
        got_ch.delete();
        chk_gap = 1;
        req = 4'b1111;
        wait_frames(5);
        req = '0;
        chk_gap = 0;
        check("rr_count", got_ch.size(), 5);
        for (int i = 0; i < 5 && i < got_ch.size(); i++) check("rr_order", got_ch[i], i % NUM_CH);

`ifdef SEQ_ARB_ABORT_EN
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        pat[2] = 16'h000D; pat[3] = 16'h036D;
        ab_len[2] = 5;
        got_ch.delete();
        req = 4'b1100;
        wait_clr();
        repeat (6) @(posedge clk);
        #2 req[2] = 1'b0;
        wait_frames(2);
        req = '0;
        check("abort_count", got_ch.size(), 2);
        if (got_ch.size() == 2) begin
            check("abort_first", got_ch[0], 2);
            check("abort_next", got_ch[1], 3);
        end
`endif

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
